i2c_frame_sequencer: RTL and testbench

- Sequences one 66-bit command frame ({opcode[1:0], operand_a[31:0], operand_b[31:0]}) into a series of single-byte I2C master transactions to the accelerator slave (FPGA B).
- After the writes, it reads back a 32-bit result.
- Sits between the UART frame source and the byte-level I2C master controller, replacing ad-hoc sequencing in the top-level state machine.
- Owns transaction ordering, handshakes with the master, result assembly and per-transaction timeout.

---
 rtl/i2c_frame_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_frame_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_frame_sequencer.sv
// i2c_frame_sequencer
// Turns one 66-bit command frame {opcode, operand_a, operand_b} into nine
// single-byte I2C writes to the accelerator slave, then reads back a result
// of RESULT_BYTES bytes. It handshakes with a byte-level I2C master and
// bounds each transaction with a timeout.
// Optional build macro: SEQ_RETRY_EN. When defined, a transaction that times
// out is reissued once before the sequencer gives up with an error.
module i2c_frame_sequencer #(
    parameter logic [6:0] SLAVE_ADDR   = 7'h07,
    parameter int         TIMEOUT_CYC  = 4096,
    parameter int         RESULT_BYTES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [65:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic        m_enable,
    output logic [6:0]  m_addr,
    output logic        m_rw,
    output logic [7:0]  m_data_in,
    input  logic        m_ready,
    input  logic        m_done,
    input  logic [7:0]  m_data_out,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        error,
    output logic [3:0]  st
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_WR_REQ  = 3'd2;
    localparam logic [2:0] S_WR_WAIT = 3'd3;
    localparam logic [2:0] S_RD_REQ  = 3'd4;
    localparam logic [2:0] S_RD_WAIT = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    // Counter wide enough to hold TIMEOUT_CYC-1 for any legal parameter value.
    localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]   TMO_ONE  = TW'(1);
    localparam logic [TW-1:0]   TMO_ZERO = TW'(0);
    localparam logic [3:0]      WR_LAST  = 4'd8;
    localparam logic [3:0]      RD_LAST  = 4'(RESULT_BYTES - 1);
    localparam logic [1:0]      OP_CFG   = 2'b11;

`ifdef SEQ_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    logic [2:0]    state_r;
    logic [65:0]   frame_r;
    logic [71:0]   queue_r;
    logic [3:0]    idx_r;
    logic [TW-1:0] tmo_r;
    logic [31:0]   shift_r;
    logic          retry_r;
    logic          frame_ready_r;
    logic          m_enable_r;
    logic          m_rw_r;
    logic [7:0]    m_data_in_r;
    logic [31:0]   result_r;
    logic          result_valid_r;
    logic          busy_r;
    logic          error_r;

    logic          tmo_hit_s;
    logic          retry_ok_s;
    logic          cfg_op_s;

    // Picks byte i of the write queue, byte 0 being the most significant.
    function automatic logic [7:0] queue_byte(input logic [71:0] q, input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = q[71:64];
            4'd1:    b = q[63:56];
            4'd2:    b = q[55:48];
            4'd3:    b = q[47:40];
            4'd4:    b = q[39:32];
            4'd5:    b = q[31:24];
            4'd6:    b = q[23:16];
            4'd7:    b = q[15:8];
            4'd8:    b = q[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign tmo_hit_s  = (tmo_r == TMO_LAST);
    // A timed-out byte is reissued only if retries are built in and it has
    // not already been retried since its last completion.
    assign retry_ok_s = RETRY_EN & ~retry_r;
    // Config ops write their nine bytes and skip the readback.
    assign cfg_op_s   = (frame_r[65:64] == OP_CFG);

    // Frame sequencing FSM together with its datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= S_IDLE;
            frame_r        <= 66'd0;
            queue_r        <= 72'd0;
            idx_r          <= 4'd0;
            tmo_r          <= TMO_ZERO;
            shift_r        <= 32'd0;
            retry_r        <= 1'b0;
            frame_ready_r  <= 1'b1;
            m_enable_r     <= 1'b0;
            m_rw_r         <= 1'b0;
            m_data_in_r    <= 8'h00;
            result_r       <= 32'd0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            m_enable_r     <= 1'b0;
            result_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (frame_valid && frame_ready_r) begin
                        frame_r       <= frame_in;
                        error_r       <= 1'b0;
                        busy_r        <= 1'b1;
                        frame_ready_r <= 1'b0;
                        state_r       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    queue_r <= {6'b000000, frame_r};
                    idx_r   <= 4'd0;
                    tmo_r   <= TMO_ZERO;
                    shift_r <= 32'd0;
                    retry_r <= 1'b0;
                    state_r <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (m_ready) begin
                        m_enable_r  <= 1'b1;
                        m_rw_r      <= 1'b0;
                        m_data_in_r <= queue_byte(queue_r, idx_r);
                        tmo_r       <= TMO_ZERO;
                        state_r     <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    // m_done wins over a timeout expiring in the same cycle.
                    if (m_done) begin
                        retry_r <= 1'b0;
                        if (idx_r == WR_LAST) begin
                            idx_r   <= 4'd0;
                            state_r <= cfg_op_s ? S_DONE : S_RD_REQ;
                        end else begin
                            idx_r   <= idx_r + 4'd1;
                            state_r <= S_WR_REQ;
                        end
                    end else if (tmo_hit_s) begin
                        if (retry_ok_s) begin
                            retry_r <= 1'b1;
                            state_r <= S_WR_REQ;
                        end else begin
                            state_r <= S_ERR;
                        end
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end
                S_RD_REQ: begin
                    if (m_ready) begin
                        m_enable_r <= 1'b1;
                        m_rw_r     <= 1'b1;
                        tmo_r      <= TMO_ZERO;
                        state_r    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (m_done) begin
                        retry_r <= 1'b0;
                        shift_r <= {shift_r[23:0], m_data_out};
                        if (idx_r == RD_LAST) begin
                            idx_r   <= 4'd0;
                            state_r <= S_DONE;
                        end else begin
                            idx_r   <= idx_r + 4'd1;
                            state_r <= S_RD_REQ;
                        end
                    end else if (tmo_hit_s) begin
                        if (retry_ok_s) begin
                            retry_r <= 1'b1;
                            state_r <= S_RD_REQ;
                        end else begin
                            state_r <= S_ERR;
                        end
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end
                S_DONE: begin
                    // A config op did no reads, so the previous result stands.
                    if (!cfg_op_s) begin
                        result_r <= shift_r;
                    end
                    result_valid_r <= 1'b1;
                    busy_r         <= 1'b0;
                    frame_ready_r  <= 1'b1;
                    state_r        <= S_IDLE;
                end
                S_ERR: begin
                    error_r       <= 1'b1;
                    busy_r        <= 1'b0;
                    frame_ready_r <= 1'b1;
                    state_r       <= S_IDLE;
                end
                default: begin
                    busy_r        <= 1'b0;
                    frame_ready_r <= 1'b1;
                    state_r       <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_ready  = frame_ready_r;
    assign m_enable     = m_enable_r;
    assign m_addr       = SLAVE_ADDR;
    assign m_rw         = m_rw_r;
    assign m_data_in    = m_data_in_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;
    assign error        = error_r;
    assign st           = {1'b0, state_r};

endmodule

// File: tb/tb_i2c_frame_sequencer.sv
// Bench for i2c_frame_sequencer: a behavioural I2C master responder, a table
// of directed frames, multi-cycle corner sequences and random frames checked
// against a frame-level reference model.
`timescale 1ns/1ps
module tb_i2c_frame_sequencer;
    localparam int TMO = 64;
    localparam int NRD = 4;
`ifdef SEQ_RETRY_EN
    localparam int RETRY = 1;
`else
    localparam int RETRY = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [65:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic        m_enable;
    logic [6:0]  m_addr;
    logic        m_rw;
    logic [7:0]  m_data_in;
    logic        m_ready;
    logic        m_done;
    logic [7:0]  m_data_out;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic        error;
    logic [3:0]  st;

    always #5 clk = ~clk;

    i2c_frame_sequencer #(.SLAVE_ADDR(7'h07), .TIMEOUT_CYC(TMO), .RESULT_BYTES(NRD)) dut (
        .clk(clk), .reset_n(reset_n), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .m_enable(m_enable), .m_addr(m_addr), .m_rw(m_rw),
        .m_data_in(m_data_in), .m_ready(m_ready), .m_done(m_done), .m_data_out(m_data_out),
        .result(result), .result_valid(result_valid), .busy(busy), .error(error), .st(st)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rd;       // read bytes, first byte most significant
        int          hang;     // write index the master never completes, -1 none
        bit          stall;    // hold m_ready low 500 cycles before third write
        int          lat;      // master response latency
        logic [31:0] exp_res;
        bit          exp_err;
    } vec_t;

    vec_t vt[5];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // master responder / monitor state
    logic [8:0]  en_q[$];
    int          en_t[$];
    logic [31:0] rv_q[$];
    int          nwr_done = 0, nrd = 0, hang_idx = -1, lat = 10;
    int          stall_left = 0, err_t = -1, lat_left = 0;
    bit          stall_req = 1'b0, pend = 1'b0, cur_rw = 1'b0, rdy_seen;
    logic [7:0]  cur_data = 8'h00;
    logic [31:0] rd_word = 32'd0;
    int          proto_bad = 0, hold_bad = 0, busy_bad = 0, stall_err = 0;
    logic [31:0] model_result = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // byte k of the write stream: {6'b0, frame} read as nine bytes MSB first
    function automatic logic [7:0] wbyte(input logic [65:0] f, input int k);
        logic [71:0] q;
        q = {6'b000000, f};
        return 8'(q >> (8 * (8 - k)));
    endfunction

    // Master model and monitor, acting 1 ns after each rising edge
    initial begin
        m_ready = 1'b1; m_done = 1'b0; m_data_out = 8'h00;
        forever begin
            @(posedge clk); #1;
            cyc++;
            rdy_seen = m_ready;
            m_done = 1'b0;
            if (!reset_n) begin
                pend = 1'b0; m_ready = 1'b1; stall_left = 0;
            end else begin
                if (pend && (m_rw !== cur_rw || (!cur_rw && m_data_in !== cur_data))) hold_bad++;
                if (m_enable) begin
                    en_q.push_back({m_rw, m_data_in});
                    en_t.push_back(cyc);
                    if (!rdy_seen || pend) proto_bad++;
                    if (!(!m_rw && nwr_done == hang_idx)) begin
                        pend = 1'b1; cur_rw = m_rw; cur_data = m_data_in;
                        lat_left = lat; m_ready = 1'b0;
                    end
                end else if (pend) begin
                    lat_left--;
                    if (lat_left == 0) begin
                        pend = 1'b0; m_done = 1'b1; m_ready = 1'b1;
                        if (cur_rw) begin
                            m_data_out = 8'(rd_word >> (8 * (3 - nrd)));
                            nrd++;
                        end else begin
                            nwr_done++;
                            if (stall_req && nwr_done == 2) begin
                                stall_req = 1'b0; stall_left = 500; m_ready = 1'b0;
                            end
                        end
                    end
                end else if (stall_left > 0) begin
                    if (error) stall_err++;
                    stall_left--;
                    if (stall_left == 0) m_ready = 1'b1;
                end
                if (result_valid) rv_q.push_back(result);
                if (busy !== (st != 4'd0)) busy_bad++;
                if (frame_ready !== (st == 4'd0)) busy_bad++;
                if (st == 4'd7 && err_t < 0) err_t = cyc;
            end
        end
    end

    task automatic arm(input vec_t v);
        en_q.delete(); en_t.delete(); rv_q.delete();
        nwr_done = 0; nrd = 0; hang_idx = v.hang; stall_req = v.stall;
        rd_word = v.rd; lat = v.lat; err_t = -1;
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string nm);
        int n;
        n = 0;
        while (busy !== lvl && n < limit) begin @(posedge clk); #2; n++; end
        chk(nm, 32'(n < limit), 32'd1);
    endtask

    task automatic do_frame(input vec_t v, input string tag);
        logic [65:0] f;
        int nw, nr, exp_w, exp_r, idx;
        f = {v.op, v.a, v.b};
        arm(v);
        frame_in = f; frame_valid = 1'b1;
        wait_busy(1'b1, 50, $sformatf("%s accept", tag));
        frame_valid = 1'b0;
        chk($sformatf("%s err_clear_on_accept", tag), 32'(error), 32'd0);
        wait_busy(1'b0, 5000, $sformatf("%s finish", tag));
        @(posedge clk); #2;
        exp_w = (v.hang >= 0) ? v.hang + 1 + RETRY : 9;
        exp_r = (v.hang >= 0 || v.op == 2'b11) ? 0 : NRD;
        nw = 0; nr = 0;
        foreach (en_q[i]) begin
            if (en_q[i][8]) nr++;
            else nw++;
        end
        chk($sformatf("%s writes", tag), nw, exp_w);
        chk($sformatf("%s reads", tag), nr, exp_r);
        for (int k = 0; k < exp_w && k < en_q.size(); k++) begin
            idx = (v.hang >= 0 && k > v.hang) ? v.hang : k;
            chk($sformatf("%s wr%0d", tag, k), 32'(en_q[k]), {23'd0, 1'b0, wbyte(f, idx)});
        end
        chk($sformatf("%s rv_pulses", tag), rv_q.size(), v.exp_err ? 0 : 1);
        chk($sformatf("%s result", tag), result, v.exp_res);
        chk($sformatf("%s error", tag), 32'(error), 32'(v.exp_err));
        if (v.hang >= 0) begin
            chk($sformatf("%s err_seen", tag), 32'(err_t >= 0 && en_t.size() > 0), 32'd1);
            if (err_t >= 0 && en_t.size() > 0)
                chk($sformatf("%s err_latency", tag), err_t - en_t[en_t.size() - 1], TMO);
        end
        if (v.stall && en_t.size() >= 3) begin
            chk($sformatf("%s stall_gap", tag), 32'((en_t[2] - en_t[1]) >= 500), 32'd1);
            chk($sformatf("%s stall_error", tag), stall_err, 0);
        end
        model_result = v.exp_res;
    endtask

    initial begin
        vec_t v, va, vb;
        logic [65:0] fa, fb;
        int low;
        reset_n = 1'b0; frame_valid = 1'b0; frame_in = 66'd0;

        vt[0] = '{2'b01, 32'h12345678, 32'h87654321, 32'hDEADBEEF, -1, 1'b0, 10, 32'hDEADBEEF, 1'b0};
        vt[1] = '{2'b11, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12121212, -1, 1'b0, 10, 32'hDEADBEEF, 1'b0};
        vt[2] = '{2'b00, 32'hCAFEF00D, 32'h01020304, 32'h11223344, -1, 1'b1, 10, 32'h11223344, 1'b0};
        vt[3] = '{2'b10, 32'h12345678, 32'hAABBCCDD, 32'h99999999,  3, 1'b0, 10, 32'h11223344, 1'b1};
        vt[4] = '{2'b10, 32'h0BADC0DE, 32'hFEEDFACE, 32'hCAFEBABE, -1, 1'b0, 10, 32'hCAFEBABE, 1'b0};

        repeat (3) @(posedge clk);
        #2;
        chk("rst st", st, 4'd0);
        chk("rst frame_ready", frame_ready, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst error", error, 1'b0);
        chk("rst result", result, 32'd0);
        chk("rst m_addr", m_addr, 7'h07);
        reset_n = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < 5; i++) do_frame(vt[i], $sformatf("vec%0d", i));

        // reset while a read is outstanding
        v = '{2'b01, 32'h00000001, 32'h00000002, 32'hABCDEF01, -1, 1'b0, 10, 32'h0, 1'b0};
        arm(v);
        frame_in = {v.op, v.a, v.b}; frame_valid = 1'b1;
        wait_busy(1'b1, 50, "rstmid accept");
        frame_valid = 1'b0;
        low = 0;
        while (st !== 4'd5 && low < 1000) begin @(posedge clk); #2; low++; end
        chk("rstmid reach_rd_wait", 32'(low < 1000), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("rstmid st", st, 4'd0);
        chk("rstmid frame_ready", frame_ready, 1'b1);
        chk("rstmid busy", busy, 1'b0);
        chk("rstmid m_enable", m_enable, 1'b0);
        chk("rstmid m_rw", m_rw, 1'b0);
        chk("rstmid m_data_in", m_data_in, 8'h00);
        chk("rstmid result", result, 32'd0);
        chk("rstmid result_valid", result_valid, 1'b0);
        chk("rstmid error", error, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;
        model_result = 32'd0;
        v = '{2'b00, 32'h5A5A0000, 32'h0000A5A5, 32'h01020304, -1, 1'b0, 7, 32'h01020304, 1'b0};
        do_frame(v, "postrst");

        // random frames against the frame-level model
        for (int i = 0; i < 16; i++) begin
            v.op = 2'($urandom_range(0, 3));
            v.a = $urandom; v.b = $urandom; v.rd = $urandom;
            v.hang = -1; v.stall = 1'b0; v.lat = $urandom_range(1, 30);
            v.exp_res = (v.op == 2'b11) ? model_result : v.rd;
            v.exp_err = 1'b0;
            do_frame(v, $sformatf("rnd%0d", i));
        end

        // back-to-back frames with frame_valid held high
        va = '{2'b01, 32'h11111111, 32'h22222222, 32'h0A0B0C0D, -1, 1'b0, 5, 32'h0A0B0C0D, 1'b0};
        vb = '{2'b10, 32'hFEDCBA98, 32'h76543210, 32'h10203040, -1, 1'b0, 5, 32'h10203040, 1'b0};
        fa = {va.op, va.a, va.b}; fb = {vb.op, vb.a, vb.b};
        arm(va);
        frame_in = fa; frame_valid = 1'b1;
        wait_busy(1'b1, 50, "b2b acceptA");
        frame_in = fb;
        wait_busy(1'b0, 5000, "b2b finishA");
        rd_word = vb.rd; nrd = 0; nwr_done = 0;
        low = 0;
        while (busy !== 1'b1 && low < 50) begin @(posedge clk); #2; low++; end
        chk("b2b idle_cycles", low, 1);
        frame_valid = 1'b0;
        wait_busy(1'b0, 5000, "b2b finishB");
        @(posedge clk); #2;
        chk("b2b transactions", en_q.size(), 26);
        chk("b2b rv_pulses", rv_q.size(), 2);
        if (rv_q.size() == 2) begin
            chk("b2b resultA", rv_q[0], va.exp_res);
            chk("b2b resultB", rv_q[1], vb.exp_res);
        end
        for (int k = 0; k < 9 && (13 + k) < en_q.size(); k++)
            chk($sformatf("b2b B wr%0d", k), 32'(en_q[13 + k]), {24'd0, wbyte(fb, k)});

        chk("proto enable_while_not_ready", proto_bad, 0);
        chk("proto hold_until_done", hold_bad, 0);
        chk("proto busy_frame_ready", busy_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
